// File: rtl/flight_pkg.sv
// Shared flight-control definitions: command/tick widths, default
// prescale, pulse-generator state encoding and the period floor helper.
package flight_pkg;

    localparam int CMD_W        = 10;
    localparam int TICK_W       = 16;
    localparam int PRESCALE_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A frame needs at least one high-capable tick and one low tick.
    function automatic logic [TICK_W-1:0] period_floor(input logic [TICK_W-1:0] p);
        return (p < TICK_W'(2)) ? TICK_W'(2) : p;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One pulse channel: shadow/active command registers, width add + clamp
// against the latched frame period, and the registered SERVO output.
import flight_pkg::*;

module servo_pwm_channel (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              load,        // next edge starts a new frame
    input  logic              cont,        // next edge stays inside the current frame
    input  logic [TICK_W-1:0] fcnt_next,
    input  logic [CMD_W-1:0]  offset,      // raw OFFSET, latched at this load
    input  logic [CMD_W-1:0]  offset_act,
    input  logic [TICK_W-1:0] period_act,
    output logic              servo
);

    logic [CMD_W-1:0]  shadow;
    logic [CMD_W-1:0]  active;
    logic [CMD_W-1:0]  next_act;
    logic [CMD_W:0]    sum_cur;
    logic [CMD_W:0]    sum_new;
    logic [TICK_W-1:0] w_cur;
    logic              servo_d;

    // A strobe landing on the load cycle is already the latest command,
    // so it bypasses the shadow straight into active.
    always_comb begin
        next_act = cmd_valid ? cmd : shadow;
        sum_cur  = {1'b0, active} + {1'b0, offset_act};
        sum_new  = {1'b0, next_act} + {1'b0, offset};
        if (TICK_W'(sum_cur) >= period_act)
            w_cur = period_act - TICK_W'(1);
        else
            w_cur = TICK_W'(sum_cur);
        // The clamp never drives a nonzero width to zero (period >= 2), so
        // the first tick of a new frame is high iff the raw sum is nonzero.
        servo_d = 1'b0;
        if (load)
            servo_d = (sum_new != '0);
        else if (cont)
            servo_d = (fcnt_next < w_cur);
    end

    // Command registers: shadow follows every strobe, active only at frame start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (cmd_valid)
                shadow <= cmd;
            if (load)
                active <= next_act;
        end
    end

    // Registered pulse output; reset clears it without waiting for a clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            servo <= 1'b0;
        else
            servo <= servo_d;
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Multi-channel servo/ESC pulse generator: run/idle FSM, tick prescaler,
// frame tick counter, frame-start latching of OFFSET/PERIOD and the
// pending-command flag. Per-channel width logic lives in servo_pwm_channel.
import flight_pkg::*;

module servo_pwm_gen #(
    parameter int N_CH     = 4,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [CMD_W*N_CH-1:0] CMD,
    input  logic                  CMD_VALID,
    input  logic [CMD_W-1:0]      OFFSET,
    input  logic [TICK_W-1:0]     PERIOD,
    output logic [N_CH-1:0]       SERVO,
    output logic                  FRAME_START,
    output logic                  CMD_PENDING
);

    localparam int PCNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    state_t            state, state_d;
    logic [PCNT_W-1:0] pcnt, pcnt_d;
    logic [TICK_W-1:0] fcnt, fcnt_d;
    logic [CMD_W-1:0]  offset_act;
    logic [TICK_W-1:0] period_act;
    logic              frame_end;
    logic              load;
    logic              cont;

    assign frame_end = (pcnt == PCNT_LAST) && (fcnt == period_act - TICK_W'(1));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next state: EN is checked every cycle and aborts a frame at once.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (EN)  state_d = RUN;
            RUN:     if (!EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: frame load/continue strobes and next counter values.
    always_comb begin
        load   = 1'b0;
        cont   = 1'b0;
        pcnt_d = '0;
        fcnt_d = '0;
        if (EN) begin
            case (state)
                IDLE:    load = 1'b1;
                RUN: begin
                    load = frame_end;
                    cont = !frame_end;
                end
                default: load = 1'b0;
            endcase
        end
        if (cont) begin
            if (pcnt == PCNT_LAST) begin
                pcnt_d = '0;
                fcnt_d = fcnt + TICK_W'(1);
            end else begin
                pcnt_d = pcnt + PCNT_W'(1);
                fcnt_d = fcnt;
            end
        end
    end

    // Counters, frame parameters and frame-level flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcnt        <= '0;
            fcnt        <= '0;
            offset_act  <= '0;
            period_act  <= TICK_W'(2);
            FRAME_START <= 1'b0;
            CMD_PENDING <= 1'b0;
        end else begin
            pcnt        <= pcnt_d;
            fcnt        <= fcnt_d;
            FRAME_START <= load;
            if (load) begin
                offset_act  <= OFFSET;
                period_act  <= period_floor(PERIOD);
                CMD_PENDING <= 1'b0;
            end else if (CMD_VALID) begin
                CMD_PENDING <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_pwm_channel u_ch (
            .CLK        (CLK),
            .RST        (RST),
            .cmd_valid  (CMD_VALID),
            .cmd        (CMD[CMD_W*i +: CMD_W]),
            .load       (load),
            .cont       (cont),
            .fcnt_next  (fcnt_d),
            .offset     (OFFSET),
            .offset_act (offset_act),
            .period_act (period_act),
            .servo      (SERVO[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with PRESCALE=32. Frame periods are kept
// short (tens of ticks) so the whole run stays well below 100k clocks.
module tb_servo_pwm_gen;

    localparam int N_CH = 4;
    localparam int PS   = 32;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN = 1'b0;
    logic [10*N_CH-1:0] CMD = '0;
    logic             CMD_VALID = 1'b0;
    logic [9:0]       OFFSET = '0;
    logic [15:0]      PERIOD = '0;
    logic [N_CH-1:0]  SERVO;
    logic             FRAME_START;
    logic             CMD_PENDING;

    int n_chk  = 0;
    int n_fail = 0;

    int hi [N_CH];
    int len;
    int pend_last;

    servo_pwm_gen #(.N_CH(N_CH), .PRESCALE(PS)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .CMD         (CMD),
        .CMD_VALID   (CMD_VALID),
        .OFFSET      (OFFSET),
        .PERIOD      (PERIOD),
        .SERVO       (SERVO),
        .FRAME_START (FRAME_START),
        .CMD_PENDING (CMD_PENDING)
    );

    always #5 CLK = ~CLK;

    function automatic logic [10*N_CH-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        logic [10*N_CH-1:0] v;
        v = {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Called on the FRAME_START cycle; counts one whole frame and returns on
    // the next FRAME_START cycle. Optionally strobes scmd at frame cycle sk.
    task automatic measure(input int sk, input logic [10*N_CH-1:0] scmd);
        int k;
        int seen;
        for (int c = 0; c < N_CH; c++) hi[c] = 0;
        len  = 0;
        seen = 0;
        k    = 0;
        while (k < 4000 && seen == 0) begin
            if (k == sk) begin
                CMD       = scmd;
                CMD_VALID = 1'b1;
            end else begin
                CMD_VALID = 1'b0;
            end
            for (int c = 0; c < N_CH; c++) if (SERVO[c] === 1'b1) hi[c]++;
            pend_last = int'(CMD_PENDING);
            len++;
            k++;
            tick();
            if (FRAME_START === 1'b1) seen = 1;
        end
        CMD_VALID = 1'b0;
        chk("frame_start_seen", seen, 1);
    endtask

    task automatic chk_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_ch0"}, hi[0], e0);
        chk({tag, "_ch1"}, hi[1], e1);
        chk({tag, "_ch2"}, hi[2], e2);
        chk({tag, "_ch3"}, hi[3], e3);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_servo", int'(SERVO), 0);
        chk("rst_fs", int'(FRAME_START), 0);
        chk("rst_pend", int'(CMD_PENDING), 0);
        tick();
        RST = 1'b0;

        // Basic pulse: PERIOD=30, OFFSET=10, CMD={0,5,10,15}
        tick();
        PERIOD    = 16'd30;
        OFFSET    = 10'd10;
        CMD       = pack(0, 5, 10, 15);
        CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        chk("pend_after_strobe", int'(CMD_PENDING), 1);
        chk("idle_servo", int'(SERVO), 0);
        EN = 1'b1;
        tick();
        chk("latency_fs", int'(FRAME_START), 1);
        chk("latency_servo", int'(SERVO), 15);
        chk("latency_pend", int'(CMD_PENDING), 0);
        measure(-1, '0);
        chk_hi("basic", 10*PS, 15*PS, 20*PS, 25*PS);
        chk("basic_len", len, 30*PS);

        // Mid-frame strobe: ch0 -> 15, current frame unchanged
        measure(100, pack(15, 5, 10, 15));
        chk("mid_ch0_old", hi[0], 10*PS);
        chk("mid_pend_end", pend_last, 1);
        chk("mid_pend_cleared", int'(CMD_PENDING), 0);

        // Strobe on the FRAME_START cycle: ch0 -> 5 lands one frame later
        measure(0, pack(5, 5, 10, 15));
        chk("fs_strobe_cur", hi[0], 25*PS);
        chk("fs_strobe_pend", pend_last, 1);
        measure(-1, '0);
        chk_hi("fs_strobe_next", 15*PS, 15*PS, 20*PS, 25*PS);

        // EN low mid-pulse, then restart
        for (int i = 0; i < 50; i++) tick();
        chk("en_pre_servo", int'(SERVO), 15);
        EN = 1'b0;
        tick();
        chk("en_low_servo", int'(SERVO), 0);
        chk("en_low_fs", int'(FRAME_START), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("idle_hold_servo", int'(SERVO), 0);
        EN = 1'b1;
        tick();
        chk("restart_fs", int'(FRAME_START), 1);
        chk("restart_servo", int'(SERVO), 15);
        measure(-1, '0);
        chk("restart_ch0", hi[0], 15*PS);
        chk("restart_len", len, 30*PS);

        // Clamp: PERIOD=20, OFFSET=10, CMD=1023 everywhere
        PERIOD = 16'd20;
        measure(0, pack(1023, 1023, 1023, 1023));
        chk("pre_clamp_len", len, 30*PS);
        PERIOD = 16'd0;
        measure(-1, '0);
        chk_hi("clamp", 19*PS, 19*PS, 19*PS, 19*PS);
        chk("clamp_len", len, 20*PS);

        // PERIOD=0 floors to a 2-tick frame, width clamps to 1 tick
        PERIOD = 16'd30;
        OFFSET = 10'd0;
        measure(0, pack(0, 0, 0, 0));
        chk_hi("p0", PS, PS, PS, PS);
        chk("p0_len", len, 2*PS);

        // Zero width: FRAME_START keeps coming while SERVO stays low
        OFFSET = 10'd10;
        measure(0, pack(0, 5, 10, 15));
        chk_hi("zero", 0, 0, 0, 0);
        chk("zero_len", len, 30*PS);

        // Async reset mid-pulse
        chk("pre_rst_servo", int'(SERVO), 15);
        for (int i = 0; i < 10; i++) tick();
        CMD       = pack(7, 7, 7, 7);
        CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        chk("pre_rst_pend", int'(CMD_PENDING), 1);
        chk("pre_rst_servo2", int'(SERVO), 15);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_servo", int'(SERVO), 0);
        chk("async_rst_pend", int'(CMD_PENDING), 0);
        chk("async_rst_fs", int'(FRAME_START), 0);
        OFFSET = 10'd0;
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst_fs", int'(FRAME_START), 1);
        chk("post_rst_servo", int'(SERVO), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
